mrram_rd_sched: RTL and testbench



---
 rtl/mrram_rd_sched_if.sv | 32 +++
 rtl/mrram_rd_sched.sv | 103 ++++++++++
 tb/tb_mrram_rd_sched.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mrram_rd_sched_if.sv
// mrram_rd_sched_if: client, write and RAM-side signal bundle for the read scheduler
//   slave  : scheduler view (takes requests/write/RAM data, drives grants/returns/RAM ports)
//   master : client + RAM environment view
interface mrram_rd_sched_if #(
    parameter int MD = 16,
    parameter int DW = 32,
    parameter int nR = 3,
    parameter int nC = 8
);
    localparam int AW = $clog2(MD);
    logic [nC-1:0]    cReq;
    logic [AW*nC-1:0] cAddr;
    logic [nC-1:0]    cGnt;
    logic [nC-1:0]    cVld;
    logic [DW*nC-1:0] cData;
    logic             wReq;
    logic [AW-1:0]    wAddr;
    logic [DW-1:0]    wData;
    logic             ramWEn;
    logic [AW-1:0]    ramWAddr;
    logic [DW-1:0]    ramWData;
    logic [AW*nR-1:0] ramRAddr;
    logic [DW*nR-1:0] ramRData;
    modport slave (
        input  cReq, cAddr, wReq, wAddr, wData, ramRData,
        output cGnt, cVld, cData, ramWEn, ramWAddr, ramWData, ramRAddr
    );
    modport master (
        output cReq, cAddr, wReq, wAddr, wData, ramRData,
        input  cGnt, cVld, cData, ramWEn, ramWAddr, ramWData, ramRAddr
    );
endinterface

// File: rtl/mrram_rd_sched.sv
// mrram_rd_sched: round-robin sharing of nR RAM read ports among nC clients
//   clk, rst_n (async, active-low)
//   bus.slave : cReq/cAddr -> cGnt (comb), cVld/cData (registered, RL+1 after grant),
//               wReq/wAddr/wData passed to ramW*, ramRAddr out / ramRData in
//   MRSCHED_RAW_STALL_EN : holds off reads that hit the address being written this cycle
module mrram_rd_sched #(
    parameter int MD = 16,
    parameter int DW = 32,
    parameter int nR = 3,
    parameter int nC = 8,
    parameter int RL = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mrram_rd_sched_if.slave bus
);
    localparam int AW = $clog2(MD);
    localparam int CW = nC > 1 ? $clog2(nC) : 1;

    logic [CW-1:0]                 ptr_q, ptr_d;
    logic [RL-1:0][nR-1:0]         vld_q, vld_d;
    logic [RL-1:0][nR-1:0][CW-1:0] cli_q, cli_d;
    logic [nC-1:0]                 cvld_q, cvld_d;
    logic [DW*nC-1:0]              cdata_q, cdata_d;
    logic [nC-1:0]                 elig, gnt;
    logic [nR-1:0]                 port_vld;
    logic [nR-1:0][CW-1:0]         port_cli;
    logic [AW*nR-1:0]              raddr;
    int                            idx, n, last;

    assign bus.ramWEn   = bus.wReq;
    assign bus.ramWAddr = bus.wAddr;
    assign bus.ramWData = bus.wData;
    assign bus.ramRAddr = raddr;
    assign bus.cGnt     = gnt;
    assign bus.cVld     = cvld_q;
    assign bus.cData    = cdata_q;

`ifdef MRSCHED_RAW_STALL_EN
    always_comb begin
        for (int c = 0; c < nC; c++)
            elig[c] = !(bus.wReq && bus.cAddr[c*AW +: AW] == bus.wAddr);
    end
`else
    assign elig = '1;
`endif

    // Scan from ptr; the k-th eligible requester found takes read port k.
    always_comb begin
        gnt      = '0;
        port_vld = '0;
        port_cli = '0;
        raddr    = '0;
        n        = 0;
        last     = 0;
        idx      = 0;
        for (int i = 0; i < nC; i++) begin
            idx = (int'(ptr_q) + i) % nC;
            if (bus.cReq[idx] && elig[idx] && n < nR) begin
                gnt[idx]            = 1'b1;
                port_vld[n]         = 1'b1;
                port_cli[n]         = CW'(idx);
                raddr[n*AW +: AW]   = bus.cAddr[idx*AW +: AW];
                last                = idx;
                n                   = n + 1;
            end
        end
        ptr_d = n > 0 ? CW'((last + 1) % nC) : ptr_q;
    end

    // Tag pipeline tracks each port's read through the RAM latency; the last
    // stage lines up with ramRData and steers it to the issuing client.
    always_comb begin
        vld_d[0] = port_vld;
        cli_d[0] = port_cli;
        for (int s = 1; s < RL; s++) begin
            vld_d[s] = vld_q[s-1];
            cli_d[s] = cli_q[s-1];
        end
        cvld_d  = '0;
        cdata_d = cdata_q;
        for (int k = 0; k < nR; k++)
            if (vld_q[RL-1][k]) begin
                cvld_d[cli_q[RL-1][k]]                = 1'b1;
                cdata_d[cli_q[RL-1][k]*DW +: DW]      = bus.ramRData[k*DW +: DW];
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ptr_q   <= '0;
            vld_q   <= '0;
            cli_q   <= '0;
            cvld_q  <= '0;
            cdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            cli_q   <= cli_d;
            cvld_q  <= cvld_d;
            cdata_q <= cdata_d;
        end
endmodule

// File: tb/tb_mrram_rd_sched.sv
// tb_mrram_rd_sched: directed and random checks of the read scheduler at RL=1 and RL=2
module tb_mrram_rd_sched;
    localparam int MD = 16, DW = 32, nR = 3, nC = 8, AW = 4, W = DW * nC;

    logic clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
    logic [nC-1:0]    creq;
    logic [AW*nC-1:0] caddr;
    logic             wreq;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    mem [MD];
    logic [DW-1:0]    ref_mem [MD];
    logic [DW*nR-1:0] rd2a;
    logic [nC-1:0]    pv [4];
    logic [DW-1:0]    pd [4][nC];
    logic [nC-1:0]    el;
    int               wt [nC];
    int               ncmp = 0, nerr = 0;

    mrram_rd_sched_if #(.MD(MD), .DW(DW), .nR(nR), .nC(nC)) bus1 ();
    mrram_rd_sched_if #(.MD(MD), .DW(DW), .nR(nR), .nC(nC)) bus2 ();

    mrram_rd_sched #(.MD(MD), .DW(DW), .nR(nR), .nC(nC), .RL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mrram_rd_sched #(.MD(MD), .DW(DW), .nR(nR), .nC(nC), .RL(2)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

    always #5 clk = ~clk;

    assign bus1.cReq = creq;  assign bus2.cReq = creq;
    assign bus1.cAddr = caddr; assign bus2.cAddr = caddr;
    assign bus1.wReq = wreq;  assign bus2.wReq = wreq;
    assign bus1.wAddr = waddr; assign bus2.wAddr = waddr;
    assign bus1.wData = wdata; assign bus2.wData = wdata;

    // RAM model, read-old on same-address write; RL=1 for dut1, RL=2 for dut2.
    always @(posedge clk) begin
        if (!rst_n)
            for (int i = 0; i < MD; i++) mem[i] <= 32'hC0DE_0000 | i;
        else if (bus1.ramWEn)
            mem[bus1.ramWAddr] <= bus1.ramWData;
        for (int k = 0; k < nR; k++) begin
            bus1.ramRData[k*DW +: DW] <= mem[bus1.ramRAddr[k*AW +: AW]];
            rd2a[k*DW +: DW]          <= mem[bus2.ramRAddr[k*AW +: AW]];
        end
        bus2.ramRData <= rd2a;
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        creq = '0; caddr = '0; wreq = 1'b0; waddr = '0; wdata = '0;
        for (int c = 0; c < nC; c++) caddr[c*AW +: AW] = AW'(c);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_vld", bus1.cVld, 0);
        chk("rst_data", bus1.cData, 0);
        chk("rst_gnt", bus1.cGnt, 0);
        chk("rst_raddr", bus1.ramRAddr, 0);
        rst_n = 1'b1; rst2_n = 1'b1;
        // all clients requesting for 4 cycles
        cyc(); creq = '1; #1;
        chk("rr_a_gnt", bus1.cGnt, 8'h07); chk("rr_a_addr", bus1.ramRAddr, 12'h210); chk("rr_a_vld", bus1.cVld, 0);
        cyc(); #1;
        chk("rr_b_gnt", bus1.cGnt, 8'h38); chk("rr_b_addr", bus1.ramRAddr, 12'h543); chk("rr_b_vld", bus1.cVld, 0);
        cyc(); #1;
        chk("rr_c_gnt", bus1.cGnt, 8'hC1); chk("rr_c_addr", bus1.ramRAddr, 12'h076); chk("rr_c_vld", bus1.cVld, 8'h07);
        chk("rr_c_data1", bus1.cData[1*DW +: DW], 32'hC0DE_0001);
        cyc(); #1;
        chk("rr_d_gnt", bus1.cGnt, 8'h0E); chk("rr_d_addr", bus1.ramRAddr, 12'h321); chk("rr_d_vld", bus1.cVld, 8'h38);
        chk("rr_d_data4", bus1.cData[4*DW +: DW], 32'hC0DE_0004); chk("rl2_d_vld", bus2.cVld, 8'h07);
        cyc(); creq = '0; #1;
        chk("idle_gnt", bus1.cGnt, 0); chk("idle_addr", bus1.ramRAddr, 0); chk("rr_e_vld", bus1.cVld, 8'hC1);
        chk("rr_e_data7", bus1.cData[7*DW +: DW], 32'hC0DE_0007); chk("rr_e_data0", bus1.cData[0*DW +: DW], 32'hC0DE_0000);
        chk("rl2_e_vld", bus2.cVld, 8'h38);
        cyc(); #1;
        chk("rr_f_vld", bus1.cVld, 8'h0E); chk("rr_f_data3", bus1.cData[3*DW +: DW], 32'hC0DE_0003);
        cyc(); #1;
        chk("rr_g_vld", bus1.cVld, 0);
        // write then read-back through client 6 (ptr=4)
        cyc(); wreq = 1'b1; waddr = 4'd5; wdata = 32'hA5A5_A5A5; #1;
        chk("wr_en", bus1.ramWEn, 1); chk("wr_addr", bus1.ramWAddr, 5); chk("wr_data", bus1.ramWData, 32'hA5A5_A5A5);
        cyc(); wreq = 1'b0; caddr[6*AW +: AW] = 4'd5; creq = 8'h40; #1;
        chk("wb_gnt", bus1.cGnt, 8'h40); chk("wb_addr", bus1.ramRAddr, 12'h005); chk("wr_en_lo", bus1.ramWEn, 0);
        cyc(); creq = '0; #1;
        chk("wb_vld_early", bus1.cVld, 0);
        cyc(); #1;
        chk("wb_vld", bus1.cVld, 8'h40); chk("wb_data", bus1.cData[6*DW +: DW], 32'hA5A5_A5A5);
        // client 7 alone at ptr=7, then wrap to 0
        cyc(); caddr[7*AW +: AW] = 4'hF; creq = 8'h80; #1;
        chk("wrap_gnt", bus1.cGnt, 8'h80); chk("wrap_addr", bus1.ramRAddr, 12'h00F);
        cyc(); creq = '1; #1;
        chk("wrap_ptr0", bus1.cGnt, 8'h07); chk("wrap_addr2", bus1.ramRAddr, 12'h210);
        cyc(); creq = '0; #1;
        chk("wrap_vld", bus1.cVld, 8'h80); chk("wrap_data", bus1.cData[7*DW +: DW], 32'hC0DE_000F);
        cyc(); #1;
        chk("wrap_vld2", bus1.cVld, 8'h07);
        // read and write to the same address in one cycle (ptr=3)
        cyc(); wreq = 1'b1; waddr = 4'd9; wdata = 32'h9999_0009;
        caddr[0*AW +: AW] = 4'd9; caddr[1*AW +: AW] = 4'd3; creq = 8'h03; #1;
`ifdef MRSCHED_RAW_STALL_EN
        chk("raw_gnt", bus1.cGnt, 8'h02); chk("raw_addr", bus1.ramRAddr, 12'h003);
`else
        chk("raw_gnt", bus1.cGnt, 8'h03); chk("raw_addr", bus1.ramRAddr, 12'h039);
`endif
        cyc(); wreq = 1'b0; creq = 8'h01; #1;
        chk("raw_retry_gnt", bus1.cGnt, 8'h01); chk("raw_retry_addr", bus1.ramRAddr, 12'h009);
        cyc(); creq = '0; #1;
        chk("raw_data1", bus1.cData[1*DW +: DW], 32'hC0DE_0003);
`ifdef MRSCHED_RAW_STALL_EN
        chk("raw_vld", bus1.cVld, 8'h02);
`else
        chk("raw_vld", bus1.cVld, 8'h03); chk("raw_old", bus1.cData[0*DW +: DW], 32'hC0DE_0009);
`endif
        cyc(); #1;
        chk("raw_vld2", bus1.cVld, 8'h01); chk("raw_new", bus1.cData[0*DW +: DW], 32'h9999_0009);
        // RL=2 instance: reset one cycle after a grant discards it
        cyc(); creq = '1; #1;
        chk("rl2_pre_gnt", bus2.cGnt, 8'h0E);
        cyc(); creq = '0; rst2_n = 1'b0; #1;
        chk("rl2_rst_vld", bus2.cVld, 0); chk("rl2_rst_data", bus2.cData, 0);
        cyc(); rst2_n = 1'b1; #1;
        chk("rl2_rel_vld", bus2.cVld, 0); chk("rl2_rel_data", bus2.cData, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("rl2_post_vld", bus2.cVld, 0);
        end
        cyc(); creq = '1; #1;
        chk("rl2_ptr0", bus2.cGnt, 8'h07);
        cyc(); creq = '0; #1;
        cyc(); #1;
        chk("rl2_lat_early", bus2.cVld, 0);
        cyc(); #1;
        chk("rl2_lat_vld", bus2.cVld, 8'h07); chk("rl2_lat_data", bus2.cData[2*DW +: DW], 32'hC0DE_0002);
        repeat (3) cyc();
        // random traffic against a reference memory
        for (int i = 0; i < MD; i++) ref_mem[i] = mem[i];
        for (int s = 0; s < 4; s++) pv[s] = '0;
        for (int c = 0; c < nC; c++) wt[c] = 0;
        for (int t = 0; t < 10003; t++) begin
            int s, sp, ne;
            cyc();
            if (t < 10000) begin
                creq = nC'($urandom); caddr = $urandom; wreq = ($urandom_range(0, 2) == 0);
                waddr = AW'($urandom); wdata = $urandom;
            end else begin
                creq = '0; wreq = 1'b0;
            end
            #1;
            s = t % 4; sp = (t + 2) % 4;
            chk("rnd_vld", bus1.cVld, pv[sp]);
            for (int c = 0; c < nC; c++)
                if (pv[sp][c]) chk("rnd_data", bus1.cData[c*DW +: DW], pd[sp][c]);
            pv[sp] = '0;
            for (int c = 0; c < nC; c++)
`ifdef MRSCHED_RAW_STALL_EN
                el[c] = creq[c] && !(wreq && caddr[c*AW +: AW] == waddr);
`else
                el[c] = creq[c];
`endif
            ne = $countones(el);
            chk("rnd_gnt_subset", bus1.cGnt & ~el, 0);
            chk("rnd_gnt_cnt", $countones(bus1.cGnt), ne < nR ? ne : nR);
            for (int c = 0; c < nC; c++) begin
                if (bus1.cGnt[c]) begin
                    pv[s][c] = 1'b1;
                    pd[s][c] = ref_mem[caddr[c*AW +: AW]];
                end
                wt[c] = (creq[c] && !bus1.cGnt[c]) ? wt[c] + 1 : 0;
`ifndef MRSCHED_RAW_STALL_EN
                if (creq[c]) chk("rnd_starve", wt[c] <= 2, 1);
`endif
            end
            if (wreq) ref_mem[waddr] = wdata;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
